insn_emit: RTL and testbench

- Y86-64 instruction encoder/serializer: the write side of the instruction-byte stream that fetch/align consumes.
- Accepts one decoded instruction (icode, ifun, rA, rB, valC) through a valid/ready handshake.
- Computes its encoded length and writes its bytes, one per accepted memory cycle, into the byte-wide instruction RAM write port at consecutive addresses.
- Used by the program loader and the self-test bench to build program images in iram.

---
 rtl/insn_emit.sv | 152 +++++++++++++++
 tb/tb_insn_emit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_emit.sv
// Y86-64 instruction encoder: takes one decoded instruction and streams
// its encoded bytes into the byte-wide iram write port.
module insn_emit #(
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              org_we,
   input  logic [ADDR_W-1:0] org_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_icode,
   input  logic [3:0]        in_ifun,
   input  logic [3:0]        in_rA,
   input  logic [3:0]        in_rB,
   input  logic [63:0]       in_valC,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] pc
);

   typedef enum logic {S_IDLE, S_EMIT} state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_pc, r_addr;
   logic [3:0]        r_idx, r_len;
   logic              r_nreg;
   logic [3:0]        r_icode, r_ifun, r_rA, r_rB;
   logic [63:0]       r_valC;
   logic              r_we, r_done, r_err;
   logic [7:0]        r_wdata;

   logic       w_icode_ok, w_acc, w_wr, w_last;
   logic [3:0] w_len, w_nidx;
   logic       w_nreg;
   logic [2:0] w_vsel;
   logic [7:0] w_byte;

   assign w_icode_ok = (in_icode <= 4'hB);
   assign w_acc      = in_valid && in_ready;
   assign w_wr       = r_we && mem_ready;
   assign w_last     = (r_idx == r_len - 4'd1);
   assign w_nidx     = r_idx + 4'd1;

   always_comb begin
      w_len  = 4'd1;
      w_nreg = 1'b0;
      case (in_icode)
         4'h2, 4'h6, 4'hA, 4'hB: begin
            w_len  = 4'd2;
            w_nreg = 1'b1;
         end
         4'h3, 4'h4, 4'h5: begin
            w_len  = 4'd10;
            w_nreg = 1'b1;
         end
         4'h7, 4'h8: w_len = 4'd9;
         default: w_len = 4'd1;
      endcase
   end

   // valC bytes start right after the opcode or register byte, LSB first
   always_comb begin
      w_vsel = r_nreg ? 3'(w_nidx - 4'd2) : 3'(w_nidx - 4'd1);
      if (r_nreg && w_nidx == 4'd1)
         w_byte = {r_rA, r_rB};
      else
         w_byte = r_valC[{w_vsel, 3'b000} +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_acc && w_icode_ok) w_next = S_EMIT;
         S_EMIT: if (w_wr && w_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == S_IDLE) && !org_we;
      mem_we    = r_we;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      done      = r_done;
      err       = r_err;
      pc        = r_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= '0;
         r_addr  <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_nreg  <= 1'b0;
         r_icode <= '0;
         r_ifun  <= '0;
         r_rA    <= '0;
         r_rB    <= '0;
         r_valC  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (r_state == S_IDLE) begin
            if (org_we) begin
               r_pc <= org_addr;
            end else if (w_acc) begin
               if (!w_icode_ok) begin
                  r_err <= 1'b1;
               end else begin
                  r_icode <= in_icode;
                  r_ifun  <= in_ifun;
                  r_rA    <= in_rA;
                  r_rB    <= in_rB;
                  r_valC  <= in_valC;
                  r_len   <= w_len;
                  r_nreg  <= w_nreg;
                  r_idx   <= '0;
                  r_we    <= 1'b1;
                  r_addr  <= r_pc;
                  r_wdata <= {in_icode, in_ifun};
               end
            end
         end else if (w_wr) begin
            r_pc  <= r_pc + ADDR_W'(1);
            r_idx <= w_nidx;
            if (w_last) begin
               r_we   <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_addr  <= r_pc + ADDR_W'(1);
               r_wdata <= w_byte;
            end
         end
      end
   end

endmodule

// File: tb/tb_insn_emit.sv
// Bench for insn_emit: directed table plus random instructions checked
// against a byte-stream model built from the Y86-64 encoding rules.
module tb_insn_emit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        org_we;
   logic [63:0] org_addr;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
   logic [63:0] in_valC;
   logic        mem_we;
   logic        mem_ready;
   logic [63:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        done, err;
   logic [63:0] pc;

   always #5 clk = ~clk;

   insn_emit #(.ADDR_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .org_we(org_we), .org_addr(org_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_icode(in_icode),
      .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC),
      .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .done(done), .err(err), .pc(pc)
   );

   typedef struct packed {
      logic [63:0] a;
      logic [7:0]  d;
   } wr_t;

   typedef struct {
      bit          so;
      logic [63:0] org;
      bit          ov;
      logic [3:0]  ic, ifn, ra, rb;
      logic [63:0] vc;
      int          len;
      int          mode;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   wr_t  got[$];
   logic [7:0] exp_b[$];
   int   done_cnt, err_cnt, we_cnt;
   int   rmode;
   logic [63:0] mpc;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Encoding rules written straight from the ISA table
   function automatic int model_len(input logic [3:0] ic);
      int n;
      n = 0;
      if (ic > 4'hB) return 0;
      n = 1;
      if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) n += 1;
      if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) n += 8;
      return n;
   endfunction

   function automatic void build(input vec_t v);
      logic [63:0] c;
      exp_b.delete();
      if (v.ic > 4'hB) return;
      c = v.vc;
      exp_b.push_back({v.ic, v.ifn});
      if (v.ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB})
         exp_b.push_back({v.ra, v.rb});
      if (v.ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
         for (int i = 0; i < 8; i++) exp_b.push_back(c[8*i +: 8]);
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0: mem_ready = 1'b1;
            1: mem_ready = ~mem_ready;
            default: mem_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   logic        st_pend = 1'b0;
   logic [63:0] st_a;
   logic [7:0]  st_d;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            st_pend = 1'b0;
         end else begin
            if (st_pend && mem_we) begin
               chk("stall_addr", mem_addr, st_a);
               chk("stall_data", {56'd0, mem_wdata}, {56'd0, st_d});
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (mem_we) we_cnt++;
            if (mem_we && mem_ready) got.push_back({mem_addr, mem_wdata});
            st_pend = mem_we && !mem_ready;
            st_a = mem_addr;
            st_d = mem_wdata;
         end
      end
   end

   task automatic set_org(input logic [63:0] a, input bit with_valid);
      @(posedge clk);
      #1;
      org_we   = 1'b1;
      org_addr = a;
      in_valid = with_valid;
      in_icode = 4'h1;
      in_ifun  = 4'h0;
      @(negedge clk);
      if (with_valid) chk("org_blocks_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      org_we   = 1'b0;
      in_valid = 1'b0;
      mpc      = a;
      @(negedge clk);
      chk("org_pc", pc, a);
      if (with_valid) chk("org_no_accept", {63'd0, mem_we}, 64'd0);
   endtask

   task automatic run(input vec_t v);
      int n;
      int len;
      if (v.so) set_org(v.org, v.ov);
      build(v);
      len = v.len;
      rmode = v.mode;
      @(posedge clk);
      #1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      got.delete();
      done_cnt = 0;
      err_cnt  = 0;
      we_cnt   = 0;
      in_valid = 1'b1;
      in_icode = v.ic;
      in_ifun  = v.ifn;
      in_rA    = v.ra;
      in_rB    = v.rb;
      in_valC  = v.vc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (done || err) break;
      end
      @(posedge clk);
      #1;
      chk("timeout", {63'd0, n < 200}, 64'd1);
      if (len == 0) begin
         chk("err_pulse", 64'(err_cnt), 64'd1);
         chk("err_no_we", 64'(we_cnt), 64'd0);
         chk("err_pc", pc, mpc);
         chk("err_ready", {63'd0, in_ready}, 64'd1);
      end else begin
         chk("done_once", 64'(done_cnt), 64'd1);
         chk("no_err", 64'(err_cnt), 64'd0);
         chk("nbytes", 64'(got.size()), 64'(exp_b.size()));
         for (int i = 0; i < exp_b.size() && i < got.size(); i++) begin
            chk("byte_addr", got[i].a, mpc + 64'(i));
            chk("byte_data", {56'd0, got[i].d}, {56'd0, exp_b[i]});
         end
         if (v.mode == 0) chk("latency", 64'(n), 64'(len + 1));
         mpc = mpc + 64'(len);
         chk("pc_after", pc, mpc);
      end
   endtask

   task automatic reset_mid(input vec_t v);
      int n;
      set_org(64'd0, 1'b0);
      rmode = 0;
      @(posedge clk);
      #1;
      got.delete();
      done_cnt = 0;
      in_valid = 1'b1;
      in_icode = v.ic;
      in_ifun  = v.ifn;
      in_rA    = v.ra;
      in_rB    = v.rb;
      in_valC  = v.vc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (got.size() < 4 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach5", 64'(got.size()), 64'd4);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_we", {63'd0, mem_we}, 64'd0);
      chk("rst_addr", mem_addr, 64'd0);
      chk("rst_data", {56'd0, mem_wdata}, 64'd0);
      chk("rst_pc", pc, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mpc = 64'd0;
      repeat (4) @(negedge clk);
      chk("rst_no_done", 64'(done_cnt), 64'd0);
   endtask

   vec_t tab[9];
   vec_t rv;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      org_we = 1'b0;
      org_addr = '0;
      in_valid = 1'b0;
      in_icode = '0;
      in_ifun = '0;
      in_rA = '0;
      in_rB = '0;
      in_valC = '0;
      mem_ready = 1'b1;
      rmode = 0;
      mpc = '0;

      tab[0] = '{1, 64'h100, 1, 4'h3, 4'h0, 4'hF, 4'h0,
                 64'h0123456789ABCDEF, 10, 0};
      tab[1] = '{1, 64'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1, 0};
      tab[2] = '{0, 64'h0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1, 0};
      tab[3] = '{0, 64'h0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 1, 0};
      tab[4] = '{1, 64'h10, 0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 9, 1};
      tab[5] = '{0, 64'h0, 0, 4'hD, 4'h0, 4'h1, 4'h2, 64'h5, 0, 0};
      tab[6] = '{0, 64'h0, 0, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 2, 0};
      tab[7] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'hA, 4'h0, 4'h0, 4'hF,
                 64'h0, 2, 0};
      tab[8] = '{0, 64'h0, 0, 4'h4, 4'h0, 4'h3, 4'h5,
                 64'hDEAD_BEEF_0000_1234, 10, 0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_we", {63'd0, mem_we}, 64'd0);
      chk("reset_pc", pc, 64'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", {63'd0, in_ready}, 64'd1);
      chk("reset_addr", mem_addr, 64'd0);
      chk("reset_data", {56'd0, mem_wdata}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_err", {63'd0, err}, 64'd0);

      for (int i = 0; i < 8; i++) run(tab[i]);
      chk("wrap_pc", pc, 64'd1);

      reset_mid(tab[8]);
      tab[2].so = 0;
      run(tab[6]);
      chk("post_rst_pc", pc, 64'd2);

      for (int i = 0; i < 40; i++) begin
         rv.so   = ($urandom_range(0, 4) == 0);
         rv.org  = {$urandom, $urandom};
         rv.ov   = 1'($urandom_range(0, 1));
         rv.ic   = 4'($urandom_range(0, 15));
         rv.ifn  = 4'($urandom_range(0, 15));
         rv.ra   = 4'($urandom_range(0, 15));
         rv.rb   = 4'($urandom_range(0, 15));
         rv.vc   = {$urandom, $urandom};
         rv.len  = model_len(rv.ic);
         rv.mode = $urandom_range(0, 2);
         run(rv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
